pixel_plot_queue: RTL and testbench

- Sits between main_datapath's pixel outputs (X, Y, colour) and vga_adapter.
- Buffers pixel writes in a small FIFO and drains them to the adapter at most one per cycle, with an explicit plot strobe instead of a permanently asserted plot.
- Adds a full-screen clear sweep that repaints all 320x240 pixels with a chosen colour, used on game start and game over.
- Upstream writers get a valid/ready handshake so bursts from the user, bullet and enemy stages never lose pixels.

---
 rtl/pixel_pkg.sv | 24 ++
 rtl/pixel_fifo.sv | 68 ++++++
 rtl/pixel_plot_queue.sv | 139 +++++++++++++
 tb/tb_pixel_plot_queue.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared screen geometry, colour constants, pixel record layout and plot-queue state encoding
// for the pixel output path.
package pixel_pkg;

  localparam int SCREEN_X_MAX = 319;
  localparam int SCREEN_Y_MAX = 239;
  localparam int PIXEL_CW     = 3;

  localparam logic [PIXEL_CW-1:0] BLACK  = 3'b000;
  localparam logic [PIXEL_CW-1:0] BULLET = 3'b101;

  typedef struct packed {
    logic [8:0]          x;
    logic [7:0]          y;
    logic [PIXEL_CW-1:0] colour;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding pending pixel writes; head is visible combinationally
// and occupancy is kept in a registered level counter.
module pixel_fifo
  import pixel_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 20
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          do_push, do_pop;

  // Guards make the FIFO safe even if a caller pushes when full or pops when empty.
  assign do_push = push_i && (level_q != FULL_LVL);
  assign do_pop  = pop_i && (level_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);
  assign level_o = level_q;

endmodule

// File: rtl/pixel_plot_queue.sv
// Buffers upstream pixel writes and feeds vga_adapter one strobed pixel per cycle,
// with a full-screen raster clear sweep that takes priority over draining.
module pixel_plot_queue
  import pixel_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int X_MAX      = SCREEN_X_MAX,
  parameter int Y_MAX      = SCREEN_Y_MAX,
  parameter int CW         = PIXEL_CW
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [8:0]                  in_x,
  input  logic [7:0]                  in_y,
  input  logic [CW-1:0]               in_colour,
  input  logic                        clear_req,
  input  logic [CW-1:0]               clear_colour,
  output logic                        clear_busy,
  output logic                        clear_done,
  output logic [8:0]                  vga_x,
  output logic [7:0]                  vga_y,
  output logic [CW-1:0]               vga_colour,
  output logic                        vga_plot,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [8:0] X_LAST = 9'(X_MAX);
  localparam logic [7:0] Y_LAST = 8'(Y_MAX);

  typedef struct packed {
    logic [8:0]    x;
    logic [7:0]    y;
    logic [CW-1:0] colour;
  } entry_t;

  entry_t        wr_entry, head;
  logic [$bits(entry_t)-1:0] fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          in_range, push, pop, sweep_last;

  state_e        state_q;
  logic          rdy_q;
  logic [8:0]    sx_q;
  logic [7:0]    sy_q;
  logic [CW-1:0] clr_col_q;

  // Readiness only looks at registered occupancy, so a same-edge pop never frees a slot early.
  assign in_ready   = rdy_q && !fifo_full;
  assign in_range   = (in_x <= X_LAST) && (in_y <= Y_LAST);
  assign push       = in_valid && in_ready && in_range;
  assign pop        = (state_q == ST_DRAIN) && !clear_req && !fifo_empty;
  assign sweep_last = (sx_q == X_LAST) && (sy_q == Y_LAST);
  assign wr_entry   = {in_x, in_y, in_colour};
  assign head       = fifo_rdata;
  assign fill_level = fifo_level;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(entry_t))
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i (wr_entry),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      rdy_q      <= 1'b0;
      sx_q       <= '0;
      sy_q       <= '0;
      clr_col_q  <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      clear_busy <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      vga_plot   <= 1'b0;
      clear_done <= 1'b0;
      clear_busy <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DRAIN: begin
          if (clear_req) begin
            state_q    <= ST_CLEAR;
            sx_q       <= '0;
            sy_q       <= '0;
            clr_col_q  <= clear_colour;
            clear_busy <= 1'b1;
          end else if (pop) begin
            vga_x      <= head.x;
            vga_y      <= head.y;
            vga_colour <= head.colour;
            vga_plot   <= 1'b1;
            // Leave DRAIN on the pop that takes the last entry with nothing arriving behind it.
            if (fifo_level == LW'(1) && !push) state_q <= ST_IDLE;
            else                               state_q <= ST_DRAIN;
          end else if (!fifo_empty) begin
            state_q <= ST_DRAIN;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          vga_x      <= sx_q;
          vga_y      <= sy_q;
          vga_colour <= clr_col_q;
          vga_plot   <= 1'b1;
          clear_busy <= 1'b1;
          if (sweep_last) begin
            sx_q       <= '0;
            sy_q       <= '0;
            clear_done <= 1'b1;
            state_q    <= fifo_empty ? ST_IDLE : ST_DRAIN;
          end else if (sx_q == X_LAST) begin
            sx_q <= '0;
            sy_q <= sy_q + 1'b1;
          end else begin
            sx_q <= sx_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_plot_queue.sv
// Randomised and directed bench for pixel_plot_queue, checked every cycle against
// a queue-based model of the plot stream.
module tb_pixel_plot_queue;
  import pixel_pkg::*;

  localparam int DEPTH  = 16;
  localparam int XN     = 320;
  localparam int YN     = 240;
  localparam int NSWEEP = XN * YN;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [8:0] in_x = '0;
  logic [7:0] in_y = '0;
  logic [2:0] in_colour = '0;
  logic       clear_req = 1'b0;
  logic [2:0] clear_colour = '0;
  logic       clear_busy, clear_done;
  logic [8:0] vga_x;
  logic [7:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [4:0] fill_level;

  int n_pass = 0;
  int n_total = 0;

  logic [19:0] exp_q[$];
  int          m_level = 0;
  bit          sweeping = 0;
  int          sw_idx = 0;
  logic [2:0]  sw_col = '0;
  int          stall = 0;
  logic [19:0] prev_px = '0;

  bit sw_track = 0;
  int sw_n = 0;

  always #5 clk = ~clk;

  pixel_plot_queue dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_colour    (in_colour),
    .clear_req    (clear_req),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_plot     (vga_plot),
    .fill_level   (fill_level)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Per-cycle comparison against the model: plots come from the pending-pixel queue
  // unless a clear is in progress, in which case they follow the raster order.
  initial begin : compare
    logic        s_rst, s_v, s_rdy, s_creq;
    logic [8:0]  s_x;
    logic [7:0]  s_y;
    logic [2:0]  s_c, s_cc;
    logic [19:0] exp_px;
    logic        exp_done, exp_busy;
    forever begin
      @(posedge clk);
      s_rst = resetn; s_v = in_valid; s_rdy = in_ready; s_creq = clear_req;
      s_x = in_x; s_y = in_y; s_c = in_colour; s_cc = clear_colour;
      #1;
      if (!s_rst || !resetn) begin
        exp_q.delete();
        m_level = 0; sweeping = 0; sw_idx = 0; stall = 0; prev_px = '0;
      end else begin
        if (s_v && s_rdy && s_x < XN && s_y < YN) begin
          exp_q.push_back({s_x, s_y, s_c});
          m_level++;
        end
        if (s_creq && !sweeping) begin
          sweeping = 1; sw_idx = 0; sw_col = s_cc;
        end
        exp_busy = sweeping;
        exp_done = 1'b0;
        if (vga_plot) begin
          if (sweeping) begin
            exp_px = {9'(sw_idx % XN), 8'(sw_idx / XN), sw_col};
            chk("sweep_pixel", {vga_x, vga_y, vga_colour}, exp_px);
            sw_idx++;
            if (sw_idx == NSWEEP) begin
              exp_done = 1'b1;
              sweeping = 0;
            end
          end else begin
            chk("plot_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
              chk("drain_pixel", {vga_x, vga_y, vga_colour}, exp_q.pop_front());
              m_level--;
            end
          end
        end else begin
          chk("hold_pixel", {vga_x, vga_y, vga_colour}, prev_px);
        end
        chk("clear_done", clear_done, exp_done);
        chk("clear_busy", clear_busy, exp_busy);
        chk("fill_level", fill_level, m_level);
        chk("in_ready", in_ready, m_level < DEPTH);
        if (!sweeping && m_level > 0 && !vga_plot) stall++;
        else stall = 0;
        if (!sweeping && m_level > 0) chk("drain_stall_le2", stall <= 2, 1);
        prev_px = {vga_x, vga_y, vga_colour};
      end
    end
  end

  task automatic nedge();
    @(negedge clk);
    if (sw_track && vga_plot) begin
      sw_n++;
      if (sw_n == 1)   chk("sweep_first", {vga_x, vga_y, vga_colour}, {9'd0, 8'd0, clear_colour});
      if (sw_n == 320) chk("sweep_320th", {vga_x, vga_y, vga_colour}, {9'd319, 8'd0, clear_colour});
    end
    if (sw_track && clear_done) begin
      chk("sweep_count", sw_n, NSWEEP);
      chk("sweep_last", {vga_x, vga_y}, {9'd319, 8'd239});
      sw_track = 0;
    end
  endtask

  task automatic drive(input logic v, input int x, input int y, input int c);
    in_valid = v; in_x = 9'(x); in_y = 8'(y); in_colour = 3'(c);
  endtask

  initial begin : stim
    int plots, first_i, last_i, acc, guard;
    logic r;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_plot", vga_plot, 0);
    chk("rst_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("rst_fill", fill_level, 0);
    chk("rst_busy_done", {clear_busy, clear_done}, 0);
    chk("rst_ready", in_ready, 0);
    resetn = 1'b1;
    #1 chk("ready_before_edge", in_ready, 0);
    nedge();
    chk("ready_after_edge", in_ready, 1);

    // Single pixel latency
    drive(1, 10, 20, 5);
    nedge();
    drive(0, 0, 0, 0);
    chk("single_k_plot", vga_plot, 0);
    chk("single_k_fill", fill_level, 1);
    nedge();
    chk("single_k1_plot", vga_plot, 0);
    nedge();
    chk("single_k2_plot", vga_plot, 1);
    chk("single_k2_pixel", {vga_x, vga_y, vga_colour}, {9'd10, 8'd20, 3'd5});
    nedge();
    chk("single_k3_plot", vga_plot, 0);
    chk("single_k3_fill", fill_level, 0);
    repeat (3) nedge();

    // Streaming 50 pixels back to back
    plots = 0; first_i = -1; last_i = -1;
    for (int i = 0; i < 60; i++) begin
      if (i < 50) begin
        drive(1, i, 5, i % 8);
        chk("stream_ready", in_ready, 1);
      end else drive(0, 0, 0, 0);
      nedge();
      chk("stream_fill_le2", fill_level <= 2, 1);
      if (vga_plot) begin
        plots++;
        if (first_i < 0) first_i = i;
        last_i = i;
      end
    end
    chk("stream_plots", plots, 50);
    chk("stream_contiguous", last_i - first_i + 1, 50);

    // Out-of-range pixels between two valid ones
    plots = 0;
    for (int i = 0; i < 10; i++) begin
      case (i)
        0: drive(1, 1, 1, 2);
        1: drive(1, 320, 0, 6);
        2: drive(1, 0, 240, 7);
        3: drive(1, 2, 2, 3);
        default: drive(0, 0, 0, 0);
      endcase
      if (i < 4) chk("oor_ready", in_ready, 1);
      nedge();
      plots += int'(vga_plot);
      if (i == 0) chk("oor_fill_a", fill_level, 1);
      if (i == 1) chk("oor_fill_b", fill_level, 1);
      if (i == 2) chk("oor_fill_c", fill_level, 0);
      if (i == 3) chk("oor_fill_d", fill_level, 1);
    end
    chk("oor_plots", plots, 2);

    // Full-screen clear with pushes landing during the sweep
    clear_colour = BLACK; clear_req = 1'b1; sw_n = 0; sw_track = 1;
    nedge();
    clear_req = 1'b0;
    chk("busy_after_take", clear_busy, 1);
    repeat (50) nedge();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 100 + acc, 7, acc % 8);
      r = in_ready;
      nedge();
      if (r) acc++;
    end
    drive(0, 0, 0, 0);
    chk("clear_accepts", acc, 16);
    chk("clear_fill_full", fill_level, 16);
    chk("clear_ready_low", in_ready, 0);
    guard = 0;
    while (sw_track && guard < 80000) begin
      nedge();
      guard++;
    end
    chk("sweep_in_budget", sw_track ? 0 : 1, 1);
    sw_track = 0;
    plots = 0;
    for (int i = 0; i < 25; i++) begin
      nedge();
      plots += int'(vga_plot);
    end
    chk("post_clear_drained", plots, 16);
    chk("post_clear_fill", fill_level, 0);
    chk("post_clear_ready", in_ready, 1);
    chk("post_clear_busy", clear_busy, 0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 335), $urandom_range(0, 247),
            $urandom_range(0, 7));
      nedge();
    end
    drive(0, 0, 0, 0);
    repeat (20) nedge();
    chk("random_final_fill", fill_level, 0);

    // Reset in the middle of a sweep
    clear_colour = BULLET; clear_req = 1'b1; sw_n = 0; sw_track = 1;
    nedge();
    clear_req = 1'b0;
    guard = 0;
    while (sw_n < 1000 && guard < 1100) begin
      nedge();
      guard++;
    end
    chk("sweep_reached_1000", sw_n, 1000);
    sw_track = 0;
    #2 resetn = 1'b0;
    #1;
    chk("midrst_plot", vga_plot, 0);
    chk("midrst_xyc", {vga_x, vga_y, vga_colour}, 0);
    chk("midrst_busy_done", {clear_busy, clear_done}, 0);
    chk("midrst_fill", fill_level, 0);
    chk("midrst_ready", in_ready, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      nedge();
      chk("after_rst_quiet", {vga_plot, clear_done, clear_busy}, 0);
      chk("after_rst_fill", fill_level, 0);
    end
    chk("after_rst_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
